// File: rtl/imem_resp.sv
// Instruction memory with a single-outstanding fetch port, a fixed response
// latency, and a side program-load write port.
module imem_resp #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1,
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_ins,
    output logic          rsp_err,
    input  logic          ld_wen,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          busy
);

    localparam logic [63:0] SPAN     = 64'(DEPTH) << 2;
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_busy;
    logic [31:0]   r_rsp_ins;
    logic          r_rsp_err;
    logic [31:0]   r_mem [DEPTH];

    logic [63:0]   w_off;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_accept;

    // Address decode. An address below BASE wraps to a huge offset, so a single
    // unsigned compare against SPAN catches both ends of the range.
    always_comb begin
        w_off    = req_addr - BASE;
        w_err    = (req_addr[1:0] != 2'b00) || (w_off >= SPAN);
        w_idx    = w_off[AW+1:2];
        w_accept = req_valid & r_req_ready;
    end

    // Program-load write port; active in every state and during reset.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            r_mem[ld_addr] <= ld_wdata;
        end
    end

    // Fetch FSM. The response word is captured at the accept edge, so the
    // request address never needs to be kept and later load writes cannot
    // disturb an in-flight or held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_ins   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt       <= CNT_INIT;
                        r_rsp_ins   <= w_err ? NOP : r_mem[w_idx];
                        r_rsp_err   <= w_err;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Registered flags drive the ports directly.
    always_comb begin
        req_ready = r_req_ready;
        rsp_valid = r_rsp_valid;
        busy      = r_busy;
        rsp_ins   = r_rsp_ins;
        rsp_err   = r_rsp_err;
    end

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: three instances at LATENCY 1, 3 and 4 sharing
// the address and program-load buses, each with its own handshake and reset.
module tb_imem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          LATS [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_ins   [3];
    logic        rsp_err   [3];
    logic        busy      [3];
    logic [63:0] req_addr;
    logic        ld_wen;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] ins;
        logic        err;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            imem_resp #(
                .DEPTH   (DEPTH),
                .LATENCY (LATS[g]),
                .BASE    (BASE)
            ) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_addr  (req_addr),
                .rsp_valid (rsp_valid[g]),
                .rsp_ready (rsp_ready[g]),
                .rsp_ins   (rsp_ins[g]),
                .rsp_err   (rsp_err[g]),
                .ld_wen    (ld_wen),
                .ld_addr   (ld_addr),
                .ld_wdata  (ld_wdata),
                .busy      (busy[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_wen   = 1'b1;
        ld_addr  = a;
        ld_wdata = d;
    endtask

    // One fetch with rsp_ready held high; optional load write on the accept edge.
    task automatic request(input int k, input string nm, input logic [63:0] addr,
                           input logic [31:0] e_ins, input logic e_err,
                           input logic same_ld, input logic [9:0] la, input logic [31:0] ld_d);
        int cyc;
        @(negedge clk);
        req_addr     = addr;
        req_valid[k] = 1'b1;
        rsp_ready[k] = 1'b1;
        if (same_ld) begin
            ld_wen   = 1'b1;
            ld_addr  = la;
            ld_wdata = ld_d;
        end
        chk({nm, "_ready"}, 64'(req_ready[k]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        ld_wen       = 1'b0;
        req_addr     = 64'hFFFF_0000_1234_5670;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid[k] && cyc < 20);
        chk({nm, "_lat"}, 64'(cyc), 64'(LATS[k]));
        chk({nm, "_ins"}, 64'(rsp_ins[k]), 64'(e_ins));
        chk({nm, "_err"}, 64'(rsp_err[k]), 64'(e_err));
        @(negedge clk);
        chk({nm, "_idle"}, {62'd0, req_ready[k], busy[k]}, 64'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;

        vt[0] = '{64'h0000_0000_8000_0000, 32'h0000_0093, 1'b0};
        vt[1] = '{64'h0000_0000_8000_0004, 32'hA500_0001, 1'b0};
        vt[2] = '{64'h0000_0000_8000_003C, 32'hA500_000F, 1'b0};
        vt[3] = '{64'h0000_0000_8000_0FFC, 32'h1234_5678, 1'b0};
        vt[4] = '{64'h0000_0000_8000_0002, 32'h0000_0013, 1'b1};
        vt[5] = '{64'h0000_0000_7FFF_FFFC, 32'h0000_0013, 1'b1};
        vt[6] = '{64'h0000_0000_8000_1000, 32'h0000_0013, 1'b1};
        vt[7] = '{64'h0000_0000_0000_0000, 32'h0000_0013, 1'b1};
        vt[8] = '{64'hFFFF_FFFF_8000_0000, 32'h0000_0013, 1'b1};
        vt[9] = '{64'h0000_0000_8000_0021, 32'h0000_0013, 1'b1};

        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b0;
        end
        req_addr = '0;
        ld_wen   = 1'b0;
        ld_addr  = '0;
        ld_wdata = '0;

        // Program load happens while reset is held.
        load(10'd0, 32'h0000_0093);
        for (int i = 1; i < 16; i++) load(10'(i), 32'hA500_0000 | 32'(i));
        load(10'd1023, 32'h1234_5678);
        @(negedge clk);
        ld_wen = 1'b0;

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 64'(rsp_valid[k]), 64'd0);
            chk($sformatf("rst_err%0d", k),   64'(rsp_err[k]),   64'd0);
            chk($sformatf("rst_ins%0d", k),   64'(rsp_ins[k]),   64'd0);
            chk($sformatf("rst_busy%0d", k),  64'(busy[k]),      64'd0);
            chk($sformatf("rst_ready%0d", k), 64'(req_ready[k]), 64'd1);
            rst[k] = 1'b0;
        end

        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 10; v++) begin
                request(k, $sformatf("vec%0d_l%0d", v, LATS[k]), vt[v].addr,
                        vt[v].ins, vt[v].err, 1'b0, 10'd0, 32'd0);
            end
        end

        // Held response on LATENCY=3: stray req_valid and a load write to the
        // same word must not disturb it.
        @(negedge clk);
        req_addr     = 64'h0000_0000_8000_0004;
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 64'h0000_0000_8000_0008;
        cyc  = 0;
        seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (req_ready[1]) seen++;
            if (cyc == 1) begin
                ld_wen   = 1'b1;
                ld_addr  = 10'd1;
                ld_wdata = 32'h5555_AAAA;
            end else begin
                ld_wen = 1'b0;
            end
        end while (!rsp_valid[1] && cyc < 20);
        chk("hold_lat", 64'(cyc), 64'd3);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready[1]) seen++;
            chk($sformatf("hold_ins%0d", c), {31'd0, rsp_valid[1], rsp_ins[1]},
                {31'd0, 1'b1, 32'hA500_0001});
        end
        chk("hold_ready_low", 64'(seen), 64'd0);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("hold_release", {61'd0, req_ready[1], busy[1], rsp_valid[1]}, 64'b100);
        request(1, "hold_newword", 64'h0000_0000_8000_0004, 32'h5555_AAAA, 1'b0, 1'b0, 10'd0, 32'd0);

        // Load write on the accept edge returns the old word.
        request(0, "same_edge_old", 64'h0000_0000_8000_0014, 32'hA500_0005, 1'b0,
                1'b1, 10'd5, 32'hDEAD_BEEF);
        request(0, "same_edge_new", 64'h0000_0000_8000_0014, 32'hDEAD_BEEF, 1'b0,
                1'b0, 10'd0, 32'd0);

        // Reset two cycles into a LATENCY=4 wait; a load during reset persists.
        @(negedge clk);
        req_addr     = 64'h0000_0000_8000_0008;
        req_valid[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("rstw_busy", {62'd0, busy[2], rsp_valid[2]}, 64'b10);
        @(negedge clk);
        rst[2]   = 1'b1;
        ld_wen   = 1'b1;
        ld_addr  = 10'd3;
        ld_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        rst[2] = 1'b0;
        ld_wen = 1'b0;
        chk("rstw_after", {61'd0, req_ready[2], busy[2], rsp_valid[2]}, 64'b100);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) seen++;
        end
        chk("rstw_no_rsp", 64'(seen), 64'd0);
        request(2, "rstw_refetch", 64'h0000_0000_8000_0008, 32'hA500_0002, 1'b0, 1'b0, 10'd0, 32'd0);
        request(2, "rstw_ldrst", 64'h0000_0000_8000_000C, 32'h0BAD_F00D, 1'b0, 1'b0, 10'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit instruction words stored (power of two, >= 16).
REQ-002 Parameter LATENCY, default 1, cycles from request acceptance to rsp_valid assertion (legal 1..4).
REQ-003 Parameter BASE, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  block can accept a fetch request this cycle.
REQ-008 req_addr  input  64  byte address of instruction (the core's pc).
REQ-009 rsp_valid  output  1  rsp_ins/rsp_err hold a completed response.
REQ-010 rsp_ready  input  1  requester consumes the response this cycle.
REQ-011 rsp_ins  output  32  fetched instruction word.
REQ-012 rsp_err  output  1  request was misaligned or out of range.
REQ-013 ld_wen  input  1  program-load write enable.
REQ-014 ld_addr  input  log2(DEPTH)  word index for program-load write.
REQ-015 ld_wdata  input  32  program-load write data.
REQ-016 busy  output  1  a request is accepted and not yet consumed.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP); busy = (state!=IDLE).
REQ-018 Accept = req_valid & req_ready; on accept the block SHALL latch req_addr, compute the response, load counter cnt = LATENCY-1, and go to RESP if LATENCY==1, otherwise to WAIT.
REQ-019 In WAIT, cnt SHALL decrement by 1 each cycle; at cnt==1 the next state SHALL be RESP, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 In RESP, rsp_ins and rsp_err SHALL stay stable until rsp_valid & rsp_ready; on that handshake the FSM SHALL return to IDLE (req_ready=1 the following cycle; no same-cycle re-accept).
REQ-021 Only one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored, and req_addr need not be held after acceptance.
REQ-022 Index = (req_addr - BASE) >> 2; the subtraction is 64-bit unsigned.
REQ-023 Error if req_addr[1:0] != 0, req_addr < BASE, or req_addr >= BASE + 4*DEPTH; then rsp_err=1 and rsp_ins=32'h0000_0013 (NOP).
REQ-024 When there is no error, rsp_ins SHALL equal mem[index] as sampled at the accept edge, and rsp_err SHALL be 0.
REQ-025 A ld_wen write SHALL update mem[ld_addr] at the clock edge in any state.
REQ-026 A load write to the index read at the same accept edge SHALL return the old data; the new data is visible to later accepts.
REQ-027 Load writes after accept SHALL NOT alter an in-flight or held response.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, cnt=0, rsp_valid=0, rsp_err=0, rsp_ins=0, busy=0; req_ready is 1 from the first cycle after reset.
REQ-029 Reset mid-WAIT or mid-RESP SHALL drop the outstanding request without emitting a response.
REQ-030 Memory contents SHALL NOT be cleared by reset, and ld_wen writes SHALL still take effect while rst=1.

Verification
REQ-031 Setup: LATENCY=1. Load mem[0]=32'h0000_0093. Request 0x8000_0000 with rsp_ready=1. Expect rsp_valid one cycle after accept, rsp_ins=32'h0000_0093, rsp_err=0, req_ready=1 the cycle after the handshake.
REQ-032 Setup: LATENCY=3. Request 0x8000_0004 with rsp_ready=0 for 5 cycles. Expect rsp_valid at accept+3 cycles, rsp_ins=mem[1] held stable, req_ready=0 throughout, IDLE after rsp_ready rises.
REQ-033 Error cases: request 0x8000_0002, then 0x7FFF_FFFC, then BASE+4*DEPTH. Expect rsp_err=1 and rsp_ins=32'h0000_0013 for each.
REQ-034 Same-edge write: ld_wen to index 5 with 32'hDEAD_BEEF at the same edge as accept of 0x8000_0014. Expect the old word; a second request to 0x8000_0014 returns 32'hDEAD_BEEF.
REQ-035 Reset during WAIT (LATENCY=4, rst pulsed at accept+2). Expect rsp_valid never asserts, busy=0 and req_ready=1 after reset, and memory contents unchanged on refetch.
